hilo_muldiv_ctrl: RTL and testbench

//  Sequences the iterative multiply/divide unit and owns the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_iter_dp.sv | 60 ++++++
 rtl/hilo_muldiv_ctrl.sv | 122 ++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and default latencies for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   localparam int MUL_CYCLES_DEF = 32;
   localparam int DIV_CYCLES_DEF = 32;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Iterative unsigned datapath: shift-add multiply (BPS bits per step) and 1-bit restoring divide.
module muldiv_iter_dp import muldiv_pkg::*; #(
   parameter int BPS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic        div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] acc
);

   logic [63:0] acc_q, acc_n, mc_q, mc_n;
   logic [31:0] mp_q, mp_n;
   logic [33:0] diff;

   always_comb begin
      acc_n = acc_q;
      mc_n  = mc_q;
      mp_n  = mp_q;
      diff  = '0;
      if (div) begin
         // acc = {remainder, dividend/quotient}; 34-bit subtract exposes the borrow
         diff = {1'b0, acc_q[63:31]} - {2'b00, mp_q};
         if (!diff[33])
            acc_n = {diff[31:0], acc_q[30:0], 1'b1};
         else
            acc_n = {acc_q[62:0], 1'b0};
      end else begin
         // extra sub-steps past bit 31 are harmless: the multiplier has drained to zero
         for (int k = 0; k < BPS; k++) begin
            if (mp_n[0])
               acc_n = acc_n + mc_n;
            mc_n = {mc_n[62:0], 1'b0};
            mp_n = {1'b0, mp_n[31:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         mc_q  <= '0;
         mp_q  <= '0;
      end else if (load) begin
         acc_q <= div ? {32'b0, a} : 64'b0;
         mc_q  <= {32'b0, a};
         mp_q  <= b;
      end else if (step) begin
         acc_q <= acc_n;
         mc_q  <= mc_n;
         mp_q  <= mp_n;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO; IDLE -> RUN -> FIX. Optional MTHI/MTLO writes
// are enabled by defining HILO_MOVE_EN.
module hilo_muldiv_ctrl import muldiv_pkg::*; #(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        StartE,
   input  logic [1:0]  OpE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        MtHiE,
   input  logic        MtLoE,
   input  logic        HiLoUseD,
   output logic        StallMD,
   output logic        Busy,
   output logic [31:0] Hi,
   output logic [31:0] Lo
);

   localparam int CW  = $clog2(imax(MUL_CYCLES, DIV_CYCLES)) + 1;
   localparam int BPS = (32 + MUL_CYCLES - 1) / MUL_CYCLES;
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

   state_t      state;
   logic [CW-1:0] cnt;
   logic        is_div, neg_q, neg_r, dz;
   logic [31:0] hi_q, lo_q;

   logic        op_div, op_sgn, ld, dp_div;
   logic [31:0] a_mag, b_mag, q_fix, r_fix;
   logic [63:0] acc, prod;

   assign op_div = (OpE == OP_DIV) || (OpE == OP_DIVU);
   assign op_sgn = (OpE == OP_MULT) || (OpE == OP_DIV);
   assign a_mag  = (op_sgn && SrcAE[31]) ? -SrcAE : SrcAE;
   assign b_mag  = (op_sgn && SrcBE[31]) ? -SrcBE : SrcBE;
   assign ld     = (state == S_IDLE) && StartE;
   assign dp_div = (state == S_IDLE) ? op_div : is_div;

   muldiv_iter_dp #(.BPS(BPS)) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ld),
      .step  (state == S_RUN),
      .div   (dp_div),
      .a     (a_mag),
      .b     (b_mag),
      .acc   (acc)
   );

   // zero divisor forces an all-ones quotient; remainder path still rebuilds the dividend
   assign prod  = neg_q ? -acc : acc;
   assign q_fix = dz ? 32'hFFFF_FFFF : (neg_q ? -acc[31:0] : acc[31:0]);
   assign r_fix = neg_r ? -acc[63:32] : acc[63:32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (StartE) begin
                  state  <= S_RUN;
                  cnt    <= '0;
                  is_div <= op_div;
                  neg_q  <= op_sgn && (SrcAE[31] ^ SrcBE[31]);
                  neg_r  <= op_sgn && SrcAE[31];
                  dz     <= op_div && (SrcBE == 32'b0);
               end
`ifdef HILO_MOVE_EN
               else begin
                  if (MtHiE) hi_q <= SrcAE;
                  if (MtLoE) lo_q <= SrcAE;
               end
`endif
            end
            S_RUN: begin
               cnt <= cnt + 1'b1;
               if (cnt == (is_div ? DIV_LAST : MUL_LAST))
                  state <= S_FIX;
            end
            S_FIX: begin
               state <= S_IDLE;
               if (is_div) begin
                  hi_q <= r_fix;
                  lo_q <= q_fix;
               end else begin
                  hi_q <= prod[63:32];
                  lo_q <= prod[31:0];
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign Busy    = (state != S_IDLE);
   assign StallMD = HiLoUseD && (Busy || StartE);
   assign Hi      = hi_q;
   assign Lo      = lo_q;

   a_start_busy: assert property (@(posedge clk) disable iff (!rst_n) !(StartE && Busy));

`ifdef HILO_MOVE_EN
   a_move_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !(StartE && !Busy && (MtHiE || MtLoE)));
`else
   logic unused_mv;
   assign unused_mv = MtHiE | MtLoE;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Bench for hilo_muldiv_ctrl: vector table plus model-driven random ops, scoreboarded,
// with hand sequences for stall, mid-op reset and (HILO_MOVE_EN) MTLO.
module tb_hilo_muldiv_ctrl;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        StartE = 1'b0, MtHiE = 1'b0, MtLoE = 1'b0, HiLoUseD = 1'b0;
   logic [1:0]  OpE = 2'b00;
   logic [31:0] SrcAE = '0, SrcBE = '0;
   logic        StallMD, Busy;
   logic [31:0] Hi, Lo;

   int vectors = 0, miscompares = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;
   typedef struct {
      logic [31:0] hi, lo;
   } exp_t;

   vec_t vt[10];
   exp_t exp_q[$];

   hilo_muldiv_ctrl dut (
      .clk(clk), .rst_n(rst_n), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
      .MtHiE(MtHiE), .MtLoE(MtLoE), .HiLoUseD(HiLoUseD), .StallMD(StallMD), .Busy(Busy),
      .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic signed [31:0] sa, sd;
      sa = a; sd = b; hi = '0; lo = '0;
      case (op)
         2'b00: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            {hi, lo} = sp;
         end
         2'b01: begin
            up = {32'b0, a} * {32'b0, b};
            {hi, lo} = up;
         end
         2'b10: begin
            if (b == 0) begin lo = '1; hi = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
            else begin lo = sa / sd; hi = sa % sd; end
         end
         default: begin
            if (b == 0) begin lo = '1; hi = a; end
            else begin lo = a / b; hi = a % b; end
         end
      endcase
   endfunction

   // One op: StartE for one cycle, then count Busy cycles (bounded) until results are readable.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_d);
      int n, stall_bad;
      exp_t e;
      @(negedge clk);
      OpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1; HiLoUseD = use_d;
      #1 chk("stall_at_start", {31'b0, StallMD}, {31'b0, use_d});
      @(negedge clk);
      StartE = 1'b0;
      n = 0; stall_bad = 0;
      while (Busy === 1'b1 && n < 200) begin
         if (use_d && StallMD !== 1'b1) stall_bad++;
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 33);
      if (use_d) begin
         chk("stall_hold", stall_bad, 0);
         chk("stall_release", {31'b0, StallMD}, 32'd0);
         HiLoUseD = 1'b0;
      end
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("hi", Hi, e.hi);
         chk("lo", Lo, e.lo);
      end
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb, mh, ml;
      vt[0] = '{2'b01, 32'hFFFF_FFFF, 32'd2,          32'd1,          32'hFFFF_FFFE};
      vt[1] = '{2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vt[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vt[3] = '{2'b11, 32'd100,        32'd7,          32'd2,          32'd14};
      vt[4] = '{2'b11, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF};
      vt[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          32'h8000_0000};
      vt[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
      vt[7] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,          32'hFFFF_FFFD};
      vt[8] = '{2'b10, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vt[9] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          32'd1};

      repeat (2) @(negedge clk);
      chk("rst_busy",  {31'b0, Busy},    32'd0);
      chk("rst_stall", {31'b0, StallMD}, 32'd0);
      chk("rst_hi", Hi, 32'd0);
      chk("rst_lo", Lo, 32'd0);
      rst_n = 1'b1;

      HiLoUseD = 1'b1;
      #1 chk("idle_use_no_stall", {31'b0, StallMD}, 32'd0);
      HiLoUseD = 1'b0;

      for (int i = 0; i < 10; i++) begin
         exp_q.push_back('{vt[i].hi, vt[i].lo});
         run_op(vt[i].op, vt[i].a, vt[i].b, 1'b0);
      end

      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom();
         rb  = (i == 3) ? 32'd0 : $urandom();
         model(rop, ra, rb, mh, ml);
         exp_q.push_back('{mh, ml});
         run_op(rop, ra, rb, 1'b0);
      end

      // dependent MFHI in Decode while the op enters EX
      exp_q.push_back('{32'hFFFF_FFFE, 32'd1});
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

      // reset in the middle of RUN aborts without touching HI/LO afterwards
      @(negedge clk);
      OpE = 2'b01; SrcAE = 32'hFFFF_FFFF; SrcBE = 32'd2; StartE = 1'b1;
      @(negedge clk);
      StartE = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrun_busy", {31'b0, Busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, Busy}, 32'd0);
      chk("abort_hi", Hi, 32'd0);
      chk("abort_lo", Lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_abort_busy", {31'b0, Busy}, 32'd0);
      chk("post_abort_hi", Hi, 32'd0);
      chk("post_abort_lo", Lo, 32'd0);

      // MTLO / MTHI in IDLE
      @(negedge clk);
      SrcAE = 32'h0000_1234; MtLoE = 1'b1;
      @(negedge clk);
      MtLoE = 1'b0;
      SrcAE = 32'hCAFE_0001; MtHiE = 1'b1;
      @(negedge clk);
      MtHiE = 1'b0;
`ifdef HILO_MOVE_EN
      chk("mtlo", Lo, 32'h0000_1234);
      chk("mthi", Hi, 32'hCAFE_0001);
`else
      chk("mtlo_ignored", Lo, 32'd0);
      chk("mthi_ignored", Hi, 32'd0);
`endif
      chk("move_not_busy", {31'b0, Busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
